// File: rtl/uart_alu_host_pkg.sv
// ============================================================================
// Module      : uart_alu_host_pkg
// Description : Shared definitions for the UART ALU host.
//               - Host FSM state encoding
//               - Frame byte indices
//               - Default widths
//               - ALU opcodes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_alu_host_pkg;

   // Default widths for the data byte and the ALU opcode.
   localparam int NB_DATA_DEF   = 8;
   localparam int NB_ALU_OP_DEF = 6;

   // Host FSM states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_WAIT_TX = 2'd2,
      ST_WAIT_RX = 2'd3
   } state_e;

   // Position of each byte within the outgoing A -> B -> OP frame.
   localparam logic [1:0] IDX_A  = 2'd0;
   localparam logic [1:0] IDX_B  = 2'd1;
   localparam logic [1:0] IDX_OP = 2'd2;

   // ALU opcodes understood by the remote ALU board.
   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_NOR = 6'h27;
   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_SRA = 6'h03;

endpackage

`default_nettype wire

// File: rtl/uart_alu_host_wait_timer.sv
// ============================================================================
// Module      : uart_alu_host_wait_timer
// Description : Saturating wait-state timer.
//               - o_expired is high once TIMEOUT_CLKS-1 enabled cycles
//                 have elapsed since the last clear.
//               - The count saturates and never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_alu_host_wait_timer #(
   parameter int TIMEOUT_CLKS = 100000
) (
   input  logic i_clk,
   input  logic i_reset,     // asynchronous, active-low
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TW-1:0] C_LAST = TW'(TIMEOUT_CLKS - 1);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   // Next count: clear has priority; otherwise count up and hold at the last value.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_enable && (count_q != C_LAST)) begin
         count_d = count_q + TW'(1);
      end
   end

   // Count register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_expired = (count_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_alu_host.sv
// ============================================================================
// Module      : uart_alu_host
// Description : Host-side initiator for the UART ALU command protocol.
//               - Sends A, B, OP through uart_tx.
//               - Waits for the one-byte result from uart_rx.
//               - Aborts with o_timeout if a wait state lasts too long.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_alu_host
   import uart_alu_host_pkg::*;
#(
   parameter int NB_DATA      = NB_DATA_DEF,
   parameter int NB_ALU_OP    = NB_ALU_OP_DEF,
   parameter int TIMEOUT_CLKS = 100000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,     // asynchronous, active-low
   input  logic                 i_start,
   input  logic [NB_DATA-1:0]   i_data_A,
   input  logic [NB_DATA-1:0]   i_data_B,
   input  logic [NB_ALU_OP-1:0] i_op,
   input  logic                 i_tx_done,
   input  logic                 i_rx_done,
   input  logic [NB_DATA-1:0]   i_rx_data,
   output logic [NB_DATA-1:0]   o_tx_data,
   output logic                 o_tx_start,
   output logic [NB_DATA-1:0]   o_result,
   output logic                 o_valid,
   output logic                 o_busy,
   output logic                 o_timeout
);

   state_e             state_q, state_d;
   logic [NB_DATA-1:0] a_q, a_d;
   logic [NB_DATA-1:0] b_q, b_d;
   logic [NB_DATA-1:0] op_q, op_d;
   logic [1:0]         idx_q, idx_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic [NB_DATA-1:0] result_q, result_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic               timer_clear;
   logic               timer_enable;
   logic               timer_expired;

   // Restart the timer on every state change; it only runs while waiting on the UART.
   assign timer_clear  = (state_d != state_q);
   assign timer_enable = (state_q == ST_WAIT_TX) || (state_q == ST_WAIT_RX);

   uart_alu_host_wait_timer #(
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) u_wait_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (timer_clear),
      .i_enable  (timer_enable),
      .o_expired (timer_expired)
   );

   // Next-state and registered-output logic; pulses default low every cycle.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      idx_d      = idx_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      result_d   = result_q;
      valid_d    = 1'b0;
      busy_d     = busy_q;
      timeout_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               a_d     = i_data_A;
               b_d     = i_data_B;
               op_d    = NB_DATA'(i_op);
               idx_d   = IDX_A;
               busy_d  = 1'b1;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            case (idx_q)
               IDX_A:   tx_data_d = a_q;
               IDX_B:   tx_data_d = b_q;
               default: tx_data_d = op_q;
            endcase
            tx_start_d = 1'b1;
            state_d    = ST_WAIT_TX;
         end

         ST_WAIT_TX: begin
            // A byte finishing takes priority over a timeout on the same cycle.
            if (i_tx_done) begin
               if (idx_q < IDX_OP) begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_WAIT_RX;
               end
            end else if (timer_expired) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         ST_WAIT_RX: begin
            // A reply arriving on the expiry cycle still counts as a result.
            if (i_rx_done) begin
               result_d = i_rx_data;
               valid_d  = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end else if (timer_expired) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, operand and output registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         idx_q      <= IDX_A;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         result_q   <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         result_q   <= result_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_result   = result_q;
   assign o_valid    = valid_q;
   assign o_busy     = busy_q;
   assign o_timeout  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_host.sv
// ============================================================================
// Module      : tb_uart_alu_host
// Description : Self-checking bench for uart_alu_host.
//               - Table of request/reply vectors.
//               - Directed sequences for timeout, stray pulses, reset abort
//                 and reply-on-expiry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_alu_host;
   import uart_alu_host_pkg::*;

   localparam int NB_DATA   = 8;
   localparam int NB_ALU_OP = 6;
   localparam int TMO       = 64;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 i_start;
   logic [NB_DATA-1:0]   i_data_A;
   logic [NB_DATA-1:0]   i_data_B;
   logic [NB_ALU_OP-1:0] i_op;
   logic                 i_tx_done;
   logic                 i_rx_done;
   logic [NB_DATA-1:0]   i_rx_data;
   logic [NB_DATA-1:0]   o_tx_data;
   logic                 o_tx_start;
   logic [NB_DATA-1:0]   o_result;
   logic                 o_valid;
   logic                 o_busy;
   logic                 o_timeout;

   always #5 clk = ~clk;

   uart_alu_host #(
      .NB_DATA      (NB_DATA),
      .NB_ALU_OP    (NB_ALU_OP),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_start    (i_start),
      .i_data_A   (i_data_A),
      .i_data_B   (i_data_B),
      .i_op       (i_op),
      .i_tx_done  (i_tx_done),
      .i_rx_done  (i_rx_done),
      .i_rx_data  (i_rx_data),
      .o_tx_data  (o_tx_data),
      .o_tx_start (o_tx_start),
      .o_result   (o_result),
      .o_valid    (o_valid),
      .o_busy     (o_busy),
      .o_timeout  (o_timeout)
   );

   int checks = 0;
   int errors = 0;
   int n_txs  = 0;
   int n_val  = 0;
   int n_tmo  = 0;

   // Pulse counters.
   always @(posedge clk) begin
      if (o_tx_start) n_txs <= n_txs + 1;
      if (o_valid)    n_val <= n_val + 1;
      if (o_timeout)  n_tmo <= n_tmo + 1;
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      logic [7:0] reply;
      logic [7:0] exp_op_byte;
      logic [7:0] exp_result;
   } vec_t;

   vec_t vecs[4];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue a request and walk the three bytes out; returns with the DUT just entered WAIT_RX.
   task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [5:0] op, input bit inject);
      logic [7:0] eb;
      i_data_A = a;
      i_data_B = b;
      i_op     = op;
      i_start  = 1'b1;
      tick;
      i_start  = 1'b0;
      check("busy_after_start", 32'(o_busy), 32'd1);
      check("no_early_tx_start", 32'(o_tx_start), 32'd0);
      for (int k = 0; k < 3; k++) begin
         eb = (k == 0) ? a : (k == 1) ? b : {2'b00, op};
         tick;
         check("tx_start_pulse", 32'(o_tx_start), 32'd1);
         check("tx_data_byte", 32'(o_tx_data), 32'(eb));
         tick;
         check("tx_start_one_cycle", 32'(o_tx_start), 32'd0);
         if (inject && k == 1) begin
            i_start   = 1'b1;
            i_data_A  = 8'hEE;
            i_rx_done = 1'b1;
            i_rx_data = 8'hAA;
            tick;
            i_start   = 1'b0;
            i_rx_done = 1'b0;
         end else begin
            tick;
         end
         check("tx_data_stable", 32'(o_tx_data), 32'(eb));
         check("busy_during_frame", 32'(o_busy), 32'd1);
         i_tx_done = 1'b1;
         if (inject && k == 2) begin
            i_rx_done = 1'b1;
            i_rx_data = 8'hAA;
         end
         tick;
         i_tx_done = 1'b0;
         i_rx_done = 1'b0;
         check("no_tx_start_after_done", 32'(o_tx_start), 32'd0);
      end
   endtask

   // Deliver the reply byte and check the result handshake.
   task automatic finish_rx(input logic [7:0] reply, input logic [7:0] exp_res);
      tick;
      tick;
      check("no_valid_before_reply", 32'(o_valid), 32'd0);
      i_rx_done = 1'b1;
      i_rx_data = reply;
      tick;
      i_rx_done = 1'b0;
      check("valid_pulse", 32'(o_valid), 32'd1);
      check("result_value", 32'(o_result), 32'(exp_res));
      check("busy_falls", 32'(o_busy), 32'd0);
      tick;
      check("valid_one_cycle", 32'(o_valid), 32'd0);
      check("result_held", 32'(o_result), 32'(exp_res));
   endtask

   initial begin
      int t0;
      int v0;
      rst_n     = 1'b0;
      i_start   = 1'b0;
      i_data_A  = '0;
      i_data_B  = '0;
      i_op      = '0;
      i_tx_done = 1'b0;
      i_rx_done = 1'b0;
      i_rx_data = '0;

      vecs[0] = '{8'h05, 8'h03, OP_ADD, 8'h08, 8'h20, 8'h08};
      vecs[1] = '{8'hF0, 8'h0F, OP_AND, 8'h00, 8'h24, 8'h00};
      vecs[2] = '{8'h10, 8'h20, OP_SUB, 8'hF0, 8'h22, 8'hF0};
      vecs[3] = '{8'hFF, 8'h01, OP_XOR, 8'hFE, 8'h26, 8'hFE};

      tick;
      tick;
      check("reset_tx_data", 32'(o_tx_data), 32'd0);
      check("reset_tx_start", 32'(o_tx_start), 32'd0);
      check("reset_result", 32'(o_result), 32'd0);
      check("reset_valid", 32'(o_valid), 32'd0);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_timeout", 32'(o_timeout), 32'd0);
      rst_n = 1'b1;
      tick;

      // Table of complete transactions.
      for (int i = 0; i < 4; i++) begin
         t0 = n_txs;
         v0 = n_val;
         check("op_byte_encoding", 32'({2'b00, vecs[i].op}), 32'(vecs[i].exp_op_byte));
         send_frame(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0);
         finish_rx(vecs[i].reply, vecs[i].exp_result);
         check("three_bytes_sent", 32'(n_txs - t0), 32'd3);
         check("one_valid", 32'(n_val - v0), 32'd1);
      end

      // No reply: timeout 64 cycles after WAIT_RX entry, result untouched.
      v0 = n_val;
      send_frame(8'h11, 8'h22, OP_OR, 1'b0);
      t0 = n_tmo;
      for (int n = 1; n < TMO; n++) tick;
      check("no_early_timeout", 32'(n_tmo - t0), 32'd0);
      check("busy_while_waiting", 32'(o_busy), 32'd1);
      tick;
      check("timeout_pulse", 32'(o_timeout), 32'd1);
      check("timeout_no_valid", 32'(o_valid), 32'd0);
      check("timeout_result_kept", 32'(o_result), 32'hFE);
      check("timeout_busy_low", 32'(o_busy), 32'd0);
      tick;
      check("timeout_one_cycle", 32'(o_timeout), 32'd0);
      check("timeout_valid_count", 32'(n_val - v0), 32'd0);

      // Stray pulses in IDLE, re-start and stray bytes mid-frame.
      i_rx_done = 1'b1;
      i_rx_data = 8'hAA;
      tick;
      i_rx_done = 1'b0;
      check("stray_rx_idle_valid", 32'(o_valid), 32'd0);
      check("stray_rx_idle_result", 32'(o_result), 32'hFE);
      t0 = n_txs;
      i_tx_done = 1'b1;
      tick;
      i_tx_done = 1'b0;
      tick;
      check("stray_tx_idle_busy", 32'(o_busy), 32'd0);
      check("stray_tx_idle_start", 32'(n_txs - t0), 32'd0);
      send_frame(8'h33, 8'h44, OP_NOR, 1'b1);
      finish_rx(8'h3C, 8'h3C);
      check("inject_three_bytes", 32'(n_txs - t0), 32'd3);
      tick;
      check("no_queued_request", 32'(o_busy), 32'd0);

      // Reply on the exact expiry cycle: result wins.
      t0 = n_tmo;
      send_frame(8'h01, 8'h02, OP_ADD, 1'b0);
      for (int n = 1; n < TMO; n++) tick;
      i_rx_done = 1'b1;
      i_rx_data = 8'h5A;
      tick;
      i_rx_done = 1'b0;
      check("expiry_valid", 32'(o_valid), 32'd1);
      check("expiry_no_timeout", 32'(o_timeout), 32'd0);
      check("expiry_result", 32'(o_result), 32'h5A);
      tick;
      check("expiry_timeout_count", 32'(n_tmo - t0), 32'd0);

      // Reset while waiting for byte A to finish.
      i_data_A = 8'h05;
      i_data_B = 8'h03;
      i_op     = OP_ADD;
      i_start  = 1'b1;
      tick;
      i_start  = 1'b0;
      tick;
      check("pre_reset_tx_start", 32'(o_tx_start), 32'd1);
      rst_n = 1'b0;
      #2;
      check("async_rst_busy", 32'(o_busy), 32'd0);
      check("async_rst_tx_start", 32'(o_tx_start), 32'd0);
      check("async_rst_tx_data", 32'(o_tx_data), 32'd0);
      check("async_rst_result", 32'(o_result), 32'd0);
      tick;
      rst_n = 1'b1;
      tick;
      send_frame(8'h05, 8'h03, OP_ADD, 1'b0);
      finish_rx(8'h08, 8'h08);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
